// File: rtl/online_arith_pkg.sv
// Shared radix arithmetic helpers and FSM state type for the online
// (MSD-first) signed-digit adder.
package online_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int radix(input int log2r);
    return 1 << log2r;
  endfunction

  function automatic int dig_width(input int log2r);
    return log2r + 1;
  endfunction

  // Maximally redundant digit set {-A..A}, A = r-1.
  function automatic int dig_bound(input int log2r);
    return radix(log2r) - 1;
  endfunction

  function automatic logic digit_in_range(input int d, input int log2r);
    return (d >= -dig_bound(log2r)) && (d <= dig_bound(log2r));
  endfunction

endpackage

// File: rtl/online_tw.sv
// Transfer/interim digit split of one digit-pair sum: p = x + y = t*r + w.
module online_tw
  import online_arith_pkg::*;
#(
  parameter int LOG2R = 2
) (
  input  logic signed [LOG2R:0] xi,
  input  logic signed [LOG2R:0] yi,
  output logic signed [1:0]     t,
  output logic signed [LOG2R:0] w
);

  localparam int DW = dig_width(LOG2R);
  localparam logic signed [DW:0] R_P = (DW+1)'(radix(LOG2R));
  localparam logic signed [DW:0] A_P = (DW+1)'(dig_bound(LOG2R));

  logic signed [DW:0] p;

  // One guard bit keeps the pair sum exact, including the -r error digit.
  assign p = {xi[DW-1], xi} + {yi[DW-1], yi};

  always_comb begin
    t = 2'sb00;
    w = DW'(p);
    if (p >= A_P) begin
      t = 2'sb01;
      w = DW'(p - R_P);
    end else if (p <= -A_P) begin
      t = 2'sb11;
      w = DW'(p + R_P);
    end
  end

endmodule

// File: rtl/online_adder_stream.sv
// Streaming online adder: MSD-first digit pairs in, NDIG+1 result digits out
// with online delay 1, single-entry output register with valid/ready.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first digit pair of a frame
//   ST_RUN   | mid-frame, each accept emits w_(j-1) + t_j
//   ST_FLUSH | last pair taken, emit the held w as the final digit
module online_adder_stream
  import online_arith_pkg::*;
#(
  parameter int LOG2R  = 2,
  parameter int MAXDIG = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic signed [LOG2R:0] xi,
  input  logic signed [LOG2R:0] yi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic signed [LOG2R:0] zi,
  output logic                 dig_err,
  output logic                 len_err
);

  localparam int DW = dig_width(LOG2R);
  localparam int CW = $clog2(MAXDIG + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXDIG);

  state_e                state_q, state_d;
  logic signed [DW-1:0]  zi_q, zi_d;
  logic signed [DW-1:0]  w_q, w_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dig_err_q, dig_err_d;
  logic                  len_err_q, len_err_d;

  logic signed [1:0]     t_cur;
  logic signed [DW-1:0]  w_cur;
  logic                  slot_free;
  logic                  accept;
  logic                  pair_bad;

  online_tw #(.LOG2R(LOG2R)) u_tw (
    .xi (xi),
    .yi (yi),
    .t  (t_cur),
    .w  (w_cur)
  );

  assign slot_free = !out_valid_q || out_ready;
  // Gated by reset_n so the block never advertises readiness while held in reset.
  assign in_ready  = reset_n && (state_q != ST_FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign pair_bad  = !digit_in_range(int'(xi), LOG2R) || !digit_in_range(int'(yi), LOG2R);

  always_comb begin
    state_d     = state_q;
    zi_d        = zi_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    dig_err_d   = dig_err_q;
    len_err_d   = len_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          zi_d        = DW'(t_cur);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          w_d         = w_cur;
          cnt_d       = CW'(1);
          dig_err_d   = pair_bad;
          len_err_d   = 1'b0;
          state_d     = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          zi_d        = w_q + DW'(t_cur);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          w_d         = w_cur;
          dig_err_d   = dig_err_q | pair_bad;
          if (cnt_q == CNT_MAX) begin
            len_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (in_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          zi_d        = w_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      zi_q        <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      dig_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      zi_q        <= zi_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
      dig_err_q   <= dig_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign zi        = zi_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign dig_err   = dig_err_q;
  assign len_err   = len_err_q;

endmodule
